plca_segment_scheduler: RTL and testbench

Central transmit-opportunity scheduler for the 16-node 10 Mb/s multidrop mixing segment. It issues a BEACON, then grants one-hot transmit opportunities to node IDs 0..N-1 in round robin, using a to_timer and optional burst extension. It polices tx_activity for unauthorised or overlapping transmissions and reports collisions and errors. It sits beside the DTE array on the shared BI_DA pair and drives each node's grant input.

---
 rtl/plca_segment_scheduler_pkg.sv | 29 ++
 rtl/plca_segment_scheduler_if.sv | 15 +
 rtl/plca_segment_scheduler_popcount16.sv | 19 +
 rtl/plca_segment_scheduler.sv | 157 +++++++++++++++
 tb/tb_plca_segment_scheduler.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/plca_segment_scheduler_pkg.sv
// Shared state encodings, flags and default timer values for the PLCA segment scheduler.
package plca_segment_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BEACON  = 3'd1,
    ST_WAIT_TO = 3'd2,
    ST_COMMIT  = 3'd3,
    ST_BURST   = 3'd4,
    ST_NEXT    = 3'd5,
    ST_RECOVER = 3'd6
  } sched_state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DEF_NODES       = 16;
  localparam int DEF_TO_TIMER    = 32;
  localparam int DEF_BEACON_LEN  = 20;
  localparam int DEF_MAX_BC      = 0;
  localparam int DEF_BURST_TIMER = 128;

  // Highest node ID served in a cycle; 0 or anything above 16 means a full segment.
  function automatic logic [3:0] last_node(input logic [4:0] node_count);
    if (node_count == 5'd0 || node_count > 5'd16) return 4'd15;
    return 4'(node_count - 5'd1);
  endfunction

endpackage

// File: rtl/plca_segment_scheduler_if.sv
// Node-side bus of the scheduler: per-node grant/request/activity lines and the beacon.
interface plca_segment_scheduler_if #(
  parameter int NODES = 16
);
  // grant is a one-hot transmit opportunity; the granted node answers by raising its
  // tx_activity bit (the "ready" side) and keeps it high for the whole packet. tx_req
  // is only meaningful while a node holds grant and means "another packet is pending".
  logic [NODES-1:0] grant;
  logic [NODES-1:0] tx_req;
  logic [NODES-1:0] tx_activity;
  logic             beacon;

  modport master (output grant, output beacon, input tx_req, input tx_activity);
  modport slave  (input grant, input beacon, output tx_req, output tx_activity);
endinterface

// File: rtl/plca_segment_scheduler_popcount16.sv
// Combinational activity census: more-than-one-talker and someone-other-than-owner flags.
module plca_segment_scheduler_popcount16 (
  input  logic [15:0] act,
  input  logic [3:0]  cur_id,
  output logic        multi,
  output logic        other
);
  logic [4:0]  cnt;
  logic [15:0] others;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < 16; i++) cnt = cnt + 5'(act[i]);
    others         = act;
    others[cur_id] = 1'b0;
    multi          = (cnt > 5'd1);
    other          = |others;
  end
endmodule

// File: rtl/plca_segment_scheduler.sv
// Round-robin transmit-opportunity scheduler: beacon, one-hot grants, burst extension,
// and policing of unauthorised or overlapping segment activity.
module plca_segment_scheduler
  import plca_segment_scheduler_pkg::*;
#(
  parameter int NODES       = DEF_NODES,
  parameter int TO_TIMER    = DEF_TO_TIMER,
  parameter int BEACON_LEN  = DEF_BEACON_LEN,
  parameter int MAX_BC      = DEF_MAX_BC,
  parameter int BURST_TIMER = DEF_BURST_TIMER
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [4:0]                node_count,
  plca_segment_scheduler_if.master  bus,
  output logic [3:0]                cur_id,
  output logic                      collision,
  output logic                      violation,
  output logic [15:0]               err_count,
  output logic [2:0]                state
);
  localparam logic [NODES-1:0] ONE         = NODES'(1);
  localparam logic [15:0]      BEACON_LAST = 16'(BEACON_LEN - 1);
  localparam logic [15:0]      TO_LAST     = 16'(TO_TIMER - 1);
  localparam logic [15:0]      BURST_LAST  = 16'(BURST_TIMER - 1);

  sched_state_e     st;
  logic [NODES-1:0] grant_q;
  logic             beacon_q;
  logic [15:0]      timer;
  logic [7:0]       bc;
  logic [3:0]       last_id_q;
  logic             multi, other, any_act, own_act, own_req;

  plca_segment_scheduler_popcount16 u_popcount (
    .act    (bus.tx_activity),
    .cur_id (cur_id),
    .multi  (multi),
    .other  (other)
  );

  assign any_act    = |bus.tx_activity;
  assign own_act    = bus.tx_activity[cur_id];
  assign own_req    = bus.tx_req[cur_id];
  assign bus.grant  = grant_q;
  assign bus.beacon = beacon_q;
  assign state      = st;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st        <= ST_IDLE;
      grant_q   <= '0;
      beacon_q  <= FALSE;
      cur_id    <= '0;
      collision <= FALSE;
      violation <= FALSE;
      err_count <= '0;
      timer     <= '0;
      bc        <= '0;
      last_id_q <= 4'd15;
    end else begin
      collision <= multi;
      violation <= FALSE;
      timer     <= timer + 16'd1;
      if (!enable) begin
        st       <= ST_IDLE;
        grant_q  <= '0;
        beacon_q <= FALSE;
        cur_id   <= '0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (!any_act) begin
              st       <= ST_BEACON;
              beacon_q <= TRUE;
              cur_id   <= '0;
              timer    <= '0;
            end
          end
          ST_BEACON: begin
            last_id_q <= last_node(node_count);
            if (any_act) begin
              st        <= ST_RECOVER;
              beacon_q  <= FALSE;
              grant_q   <= '0;
              violation <= TRUE;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else if (timer == BEACON_LAST) begin
              st       <= ST_WAIT_TO;
              beacon_q <= FALSE;
              grant_q  <= ONE << cur_id;
              timer    <= '0;
            end
          end
          // The owner's own activity is checked before the timer so a start on the
          // last cycle of the window still counts.
          ST_WAIT_TO, ST_COMMIT, ST_BURST: begin
            if (other) begin
              st        <= ST_RECOVER;
              grant_q   <= '0;
              violation <= TRUE;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else if (st == ST_COMMIT) begin
              if (!own_act) begin
                if (int'(bc) < MAX_BC && own_req) begin
                  st    <= ST_BURST;
                  bc    <= bc + 8'd1;
                  timer <= '0;
                end else begin
                  st      <= ST_NEXT;
                  grant_q <= '0;
                end
              end
            end else if (own_act) begin
              st <= ST_COMMIT;
              if (st == ST_WAIT_TO) bc <= '0;
            end else if ((st == ST_WAIT_TO && timer == TO_LAST) ||
                         (st == ST_BURST && timer == BURST_LAST)) begin
              st      <= ST_NEXT;
              grant_q <= '0;
            end
          end
          ST_NEXT: begin
            if (any_act) begin
              st        <= ST_RECOVER;
              violation <= TRUE;
              if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end else if (cur_id == last_id_q) begin
              st       <= ST_BEACON;
              beacon_q <= TRUE;
              cur_id   <= '0;
              timer    <= '0;
            end else begin
              st      <= ST_WAIT_TO;
              grant_q <= ONE << (cur_id + 4'd1);
              cur_id  <= cur_id + 4'd1;
              timer   <= '0;
            end
          end
          ST_RECOVER: begin
            if (!any_act) begin
              st       <= ST_BEACON;
              beacon_q <= TRUE;
              cur_id   <= '0;
              timer    <= '0;
            end
          end
          default: begin
            st      <= ST_IDLE;
            grant_q <= '0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_plca_segment_scheduler.sv
// Self-checking bench: slot timelines computed arithmetically from the scheduling rules.
module tb_plca_segment_scheduler;
  import plca_segment_scheduler_pkg::*;

  localparam int NODES       = 16;
  localparam int TO_TIMER    = 32;
  localparam int BEACON_LEN  = 20;
  localparam int MAX_BC      = 1;
  localparam int BURST_TIMER = 128;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [4:0]  node_count = 5'd4;
  logic [3:0]  cur_id;
  logic        collision, violation;
  logic [15:0] err_count;
  logic [2:0]  state;

  plca_segment_scheduler_if #(.NODES(NODES)) bus ();

  plca_segment_scheduler #(
    .NODES(NODES), .TO_TIMER(TO_TIMER), .BEACON_LEN(BEACON_LEN),
    .MAX_BC(MAX_BC), .BURST_TIMER(BURST_TIMER)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .node_count (node_count),
    .bus        (bus.master),
    .cur_id     (cur_id),
    .collision  (collision),
    .violation  (violation),
    .err_count  (err_count),
    .state      (state)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [15:0] prev_act = '0;
  logic [15:0] exp_err = '0;
  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];
  logic [4:0]  meta_q[$];

  function automatic logic [15:0] bit16(input int i);
    logic [15:0] v;
    v = '0;
    v[i[3:0]] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_common(input bit exp_viol);
    check("violation", 16'(violation), 16'(exp_viol));
    check("collision", 16'(collision), 16'($countones(prev_act) > 1));
    check("err_count", err_count, exp_err);
  endtask

  task automatic drive(input logic [15:0] a);
    bus.tx_activity = a;
    prev_act = a;
  endtask

  // One scheduling cycle from the first beacon cycle. pk: transmitting node (-1 none),
  // o: start offset into its grant, len/len2: packet lengths, gap: idle between packets.
  // vc: round cycle where nodes vj/vm intrude for vh cycles. ab: enable drop, relative
  // to pk's grant start.
  task automatic run_round(input int nc, input int pk, input int o, input int len,
                           input bit req, input int gap, input int len2, input int vc,
                           input int vj, input int vm, input int vh, input int ab);
    int n, tend, rel;
    int s[16];
    int d[16];
    logic [15:0] g, a, va;
    logic [4:0]  m;
    bit burst;
    n = (nc >= 1 && nc <= 16) ? nc : 16;
    node_count = 5'(nc);
    bus.tx_req = 16'($urandom());
    if (pk >= 0) bus.tx_req[pk] = req;
    burst = req && (MAX_BC >= 1);
    for (int i = 0; i < n; i++) begin
      d[i] = TO_TIMER;
      if (i == pk)
        d[i] = !burst ? o + len + 1 :
               (len2 > 0 ? o + len + gap + len2 + 1 : o + len + 1 + BURST_TIMER);
      s[i] = (i == 0) ? BEACON_LEN : s[i-1] + d[i-1] + 1;
    end
    tend = s[n-1] + d[n-1] + 1;
    exp_q.delete(); act_q.delete(); meta_q.delete();
    for (int t = 0; t < tend; t++) begin
      g = '0; a = '0; m = 5'h10;
      if (t >= BEACON_LEN) begin
        for (int i = 0; i < n; i++) begin
          if (t >= s[i] && t <= s[i] + d[i]) begin
            m = 5'(i);
            if (t < s[i] + d[i]) g = bit16(i);
            rel = t - s[i];
            if (i == pk && ((rel >= o && rel < o + len) ||
                (burst && len2 > 0 && rel >= o + len + gap && rel < o + len + gap + len2)))
              a = bit16(i);
          end
        end
      end
      exp_q.push_back(g); act_q.push_back(a); meta_q.push_back(m);
    end
    for (int t = 0; t < tend; t++) begin
      @(negedge clk);
      g = exp_q.pop_front(); a = act_q.pop_front(); m = meta_q.pop_front();
      check("grant", bus.grant, g);
      check("beacon", 16'(bus.beacon), 16'(m[4]));
      check("cur_id", 16'(cur_id), 16'(m[3:0]));
      check_common(1'b0);
      if (vc >= 0 && t == vc) begin
        va = bit16(vj);
        if (vm >= 0) va = va | bit16(vm);
        drive(a | va);
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        for (int k = 1; k <= vh; k++) begin
          @(negedge clk);
          check("rec_state", 16'(state), 16'(ST_RECOVER));
          check("rec_grant", bus.grant, 16'h0);
          check("rec_beacon", 16'(bus.beacon), 16'h0);
          check_common(k == 1);
          drive(k < vh ? va : 16'h0);
        end
        return;
      end
      if (ab >= 0 && pk >= 0 && t == s[pk] + ab) begin
        enable = 1'b0;
        drive(a);
        @(negedge clk);
        check("dis_state", 16'(state), 16'(ST_IDLE));
        check("dis_grant", bus.grant, 16'h0);
        check("dis_beacon", 16'(bus.beacon), 16'h0);
        check("dis_cur_id", 16'(cur_id), 16'h0);
        check_common(1'b0);
        enable = 1'b1;
        drive(16'h0021);
        @(negedge clk);
        check("idle_hold", 16'(state), 16'(ST_IDLE));
        check_common(1'b0);
        drive(16'h0);
        return;
      end
      drive(a);
    end
  endtask

  initial begin
    int nc, n, pk, vc, vj, vm;
    bus.tx_activity = '0;
    bus.tx_req = '0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_grant", bus.grant, 16'h0);
    check("rst_cur_id", 16'(cur_id), 16'h0);
    check("rst_beacon", 16'(bus.beacon), 16'h0);
    check("rst_state", 16'(state), 16'(ST_IDLE));
    check_common(1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("dis_idle_state", 16'(state), 16'(ST_IDLE));
      check("dis_idle_grant", bus.grant, 16'h0);
    end
    enable = 1'b1;

    run_round(4, -1, 0, 0, 1'b0, 0, 0, -1, 0, -1, 0, -1);
    run_round(4, 2, 5, 200, 1'b0, 0, 0, -1, 0, -1, 0, -1);
    run_round(4, 1, 3, 20, 1'b1, 50, 20, -1, 0, -1, 0, -1);
    run_round(4, 3, 10, 15, 1'b1, 0, 0, -1, 0, -1, 0, -1);
    run_round(4, -1, 0, 0, 1'b0, 0, 0, BEACON_LEN + 33 + 5, 3, -1, 10, -1);
    run_round(4, -1, 0, 0, 1'b0, 0, 0, 7, 9, 12, 3, -1);
    run_round(4, -1, 0, 0, 1'b0, 0, 0, -1, 0, -1, 0, -1);

    for (int r = 0; r < 8; r++) begin
      nc = $urandom_range(0, 9);
      if (nc == 9) nc = 17;
      n = (nc >= 1 && nc <= 16) ? nc : 16;
      pk = $urandom_range(0, n);
      if (pk == n) pk = -1;
      vc = -1; vj = 0; vm = -1;
      if (pk < 0 && n < 16 && $urandom_range(0, 1) == 1) begin
        vc = $urandom_range(0, BEACON_LEN + 33 * n - 1);
        vj = $urandom_range(n, 15);
        if ($urandom_range(0, 1) == 1) vm = $urandom_range(n, 15);
      end
      run_round(nc, pk, $urandom_range(0, TO_TIMER - 1), $urandom_range(1, 60),
                1'($urandom_range(0, 1)), $urandom_range(1, 60), $urandom_range(0, 40),
                vc, vj, vm, $urandom_range(1, 8), -1);
    end

    run_round(4, 0, 2, 40, 1'b0, 0, 0, -1, 0, -1, 0, 13);
    run_round(4, -1, 0, 0, 1'b0, 0, 0, -1, 0, -1, 0, -1);

    repeat (BEACON_LEN + 5) begin
      @(negedge clk);
      drive(16'h0);
    end
    check("pre_rst_grant", bus.grant, 16'h0001);
    #2 reset_n = 1'b0;
    exp_err = '0;
    prev_act = '0;
    #1;
    check("mid_rst_grant", bus.grant, 16'h0);
    check("mid_rst_cur_id", 16'(cur_id), 16'h0);
    check("mid_rst_beacon", 16'(bus.beacon), 16'h0);
    check("mid_rst_state", 16'(state), 16'(ST_IDLE));
    check_common(1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_round(3, 1, 0, 5, 1'b0, 0, 0, -1, 0, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
